// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared types and constants for the instruction fetch slice
package sisc_pkg;

    localparam int DEFAULT_PC_W = 16;
    localparam int INSTR_W      = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: instruction memory, decode handshake, redirect
// master: fetch_unit side (drives imem_req/imem_addr, ir/ir_valid/ir_pc)
// slave : memory + control unit side (drives imem_ack/imem_data, ir_ready, br_taken/br_addr)
interface fetch_unit_if
    import sisc_pkg::*;
#(
    parameter int PC_W = DEFAULT_PC_W
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_ready;
    logic [PC_W-1:0]    ir_pc;
    logic               br_taken;
    logic [PC_W-1:0]    br_addr;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, ir_pc,
        input  imem_ack, imem_data, ir_ready, br_taken, br_addr
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, ir_pc,
        output imem_ack, imem_data, ir_ready, br_taken, br_addr
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {instr, pc} with flush
// clk, rst_f            : clock, async active-high reset
// flush_i               : empty the queue (wins over push/pop)
// push_i, push_*_i      : write one entry (never issued when full)
// pop_i                 : drop the head entry (never issued when empty)
// count_o, head_*_o     : occupancy and head entry (NOP / 0 when empty)
module fetch_queue
    import sisc_pkg::*;
#(
    parameter int PC_W  = DEFAULT_PC_W,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [PC_W-1:0]    head_pc_o
);
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            instr_mem[wr_ptr_q] <= push_instr_i;
            pc_mem[wr_ptr_q]    <= push_pc_i;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = (count_q != '0) ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign head_pc_o    = (count_q != '0) ? pc_mem[rd_ptr_q]    : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM, fetch PC and prefetch queue
// clk, rst_f : clock, async active-high reset
// bus        : fetch_unit_if.master (memory request/ack, ir handshake, redirect)
// fetch_cnt, flush_cnt : saturating push / redirect counters, only with FETCH_PERF_EN
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_f,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  fetch_cnt,
    output logic [15:0]  flush_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               start_q;
    logic [CNT_W-1:0]   count, count_after;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    logic               busy, push, pop, ir_valid_w;

    assign busy       = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign ir_valid_w = (count != '0);
    // A redirect suppresses both queue operations in its cycle
    assign push        = (state_q == ST_REQ) && bus.imem_ack && !bus.br_taken;
    assign pop         = ir_valid_w && bus.ir_ready && !bus.br_taken;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.br_taken)
            fetch_pc_d = bus.br_addr;
        else if (push)
            fetch_pc_d = fetch_pc_q + 1'b1;
    end

    // The request address freezes while a request is outstanding, so a
    // redirect during REQ/DISCARD changes only fetch_pc, never imem_addr
    assign addr_d = (busy && !bus.imem_ack) ? addr_q : fetch_pc_d;

    // start_q delays the first request by one edge after reset release
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            start_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_q && !bus.br_taken && (count < DEPTH_C))
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.br_taken)
                    state_d = bus.imem_ack ? ST_IDLE : ST_DISCARD;
                else if (bus.imem_ack)
                    state_d = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
            end
            ST_DISCARD: begin
                if (bus.imem_ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req  = busy;
        bus.imem_addr = addr_q;
        bus.ir        = head_instr;
        bus.ir_pc     = head_pc;
        bus.ir_valid  = ir_valid_w;
    end

    fetch_queue #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_f        (rst_f),
        .flush_i      (bus.br_taken),
        .push_i       (push),
        .push_instr_i (bus.imem_data),
        .push_pc_i    (addr_q),
        .pop_i        (pop),
        .count_o      (count),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != 16'hFFFF))
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (bus.br_taken && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic rst_f;
    logic auto_ack;
    logic man_ack;
    int   checks;
    int   errors;
    int   req_cnt;
    exp_t exp_q[$];

    fetch_unit_if #(.PC_W(16)) ifc ();

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    fetch_unit #(
        .PC_W     (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (ifc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Memory contents: word at address a is A000_0001 + (a << 16)
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0001 + {a, 16'h0000};
    endfunction

    assign ifc.imem_ack  = auto_ack ? ifc.imem_req : man_ack;
    assign ifc.imem_data = mem_word(ifc.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [31:0] instr, input logic [15:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed instruction must match the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst_f && ifc.ir_valid && ifc.ir_ready && !ifc.br_taken) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got ir=%h ir_pc=%h required no instruction", ifc.ir, ifc.ir_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_ir", {ifc.ir, ifc.ir_pc}, {e.instr, e.pc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_f        = 1'b1;
        auto_ack     = 1'b0;
        man_ack      = 1'b1;
        ifc.ir_ready = 1'b0;
        ifc.br_taken = 1'b0;
        ifc.br_addr  = 16'h0000;

        // Reset state, with a stray ack that must be ignored
        step(2);
        check("rst_req",   ifc.imem_req, 1'b0);
        check("rst_valid", ifc.ir_valid, 1'b0);
        check("rst_ir",    ifc.ir,       32'h0);
        check("rst_ir_pc", ifc.ir_pc,    16'h0);

        // Zero-wait streaming with ir_ready=1
        expect_instr(32'hA000_0001, 16'h0000);
        expect_instr(32'hA001_0001, 16'h0001);
        expect_instr(32'hA002_0001, 16'h0002);
        expect_instr(32'hA003_0001, 16'h0003);
        expect_instr(32'hA004_0001, 16'h0004);
        expect_instr(32'hA005_0001, 16'h0005);
        expect_instr(32'hA006_0001, 16'h0006);
        expect_instr(32'hA007_0001, 16'h0007);
        rst_f        = 1'b0;
        man_ack      = 1'b0;
        auto_ack     = 1'b1;
        ifc.ir_ready = 1'b1;
        step(1);
        check("first_edge_no_req", ifc.imem_req, 1'b0);
        step(1);
        check("first_req",      ifc.imem_req,  1'b1);
        check("first_req_addr", ifc.imem_addr, 16'h0000);
        step(1);
        check("first_ir",       {ifc.ir_valid, ifc.ir, ifc.ir_pc}, {1'b1, 32'hA000_0001, 16'h0000});
        check("second_addr",    ifc.imem_addr, 16'h0001);
        step(5);

        // Back-pressure: queue fills to DEPTH and requests stop
        ifc.ir_ready = 1'b0;
        step(3);
        check("full_req",  ifc.imem_req, 1'b0);
        check("full_head", {ifc.ir_valid, ifc.ir, ifc.ir_pc}, {1'b1, 32'hA005_0001, 16'h0005});
        ifc.ir_ready = 1'b1;
        step(1);
        ifc.ir_ready = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (ifc.imem_req) req_cnt++;
        end
        check("one_refill_req", req_cnt, 1);
        check("refill_head",    {ifc.imem_req, ifc.ir_pc}, {1'b0, 16'h0006});

        // Drain with memory stalled; request to address 8 stays outstanding
        auto_ack     = 1'b0;
        ifc.ir_ready = 1'b1;
        step(2);
        check("stall_req", {ifc.imem_req, ifc.imem_addr, ifc.ir_valid}, {1'b1, 16'h0008, 1'b0});

        // Redirect while waiting, ack three cycles later is dropped
        ifc.br_taken = 1'b1;
        ifc.br_addr  = 16'h0040;
        step(1);
        ifc.br_taken = 1'b0;
        check("discard_hold", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'h0008});
        step(2);
        man_ack = 1'b1;
        step(1);
        man_ack = 1'b0;
        check("discard_done", {ifc.imem_req, ifc.ir_valid}, {1'b0, 1'b0});
        step(1);
        check("redirect_req", {ifc.imem_req, ifc.imem_addr, ifc.ir_valid}, {1'b1, 16'h0040, 1'b0});

        // Redirect coincident with ack and pop
        auto_ack = 1'b1;
        step(1);
        check("pre_flush_head", {ifc.ir_valid, ifc.ir, ifc.ir_pc}, {1'b1, 32'hA040_0001, 16'h0040});
        ifc.br_taken = 1'b1;
        ifc.br_addr  = 16'h1234;
        step(1);
        ifc.br_taken = 1'b0;
        auto_ack     = 1'b0;
        check("flush_empty", {ifc.ir_valid, ifc.imem_req}, {1'b0, 1'b0});
        step(1);
        check("flush_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'h1234});

        // Redirect with ack in REQ, then wrap from FFFF to 0000
        ifc.ir_ready = 1'b0;
        ifc.br_taken = 1'b1;
        ifc.br_addr  = 16'hFFFF;
        man_ack      = 1'b1;
        step(1);
        ifc.br_taken = 1'b0;
        man_ack      = 1'b0;
        check("br_ack_drop", {ifc.imem_req, ifc.ir_valid}, {1'b0, 1'b0});
        expect_instr(32'h9FFF_0001, 16'hFFFF);
        expect_instr(32'hA000_0001, 16'h0000);
        auto_ack = 1'b1;
        step(1);
        check("wrap_req_ffff", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'hFFFF});
        step(1);
        check("wrap_req_0000", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'h0000});
        step(1);
        check("wrap_full", {ifc.imem_req, ifc.ir, ifc.ir_pc}, {1'b0, 32'h9FFF_0001, 16'hFFFF});
        auto_ack     = 1'b0;
        ifc.ir_ready = 1'b1;
        step(2);
        check("wrap_next", {ifc.imem_req, ifc.imem_addr, ifc.ir_valid}, {1'b1, 16'h0001, 1'b0});

        // DISCARD with a second redirect, then reset mid-transaction
        ifc.br_taken = 1'b1;
        ifc.br_addr  = 16'h0077;
        step(1);
        ifc.br_addr  = 16'h0088;
        step(1);
        ifc.br_taken = 1'b0;
        check("discard_rebr", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'h0001});
        #2;
        rst_f   = 1'b1;
        man_ack = 1'b1;
        #1;
        check("async_rst_req", {ifc.imem_req, ifc.ir_valid}, {1'b0, 1'b0});
        step(2);
        check("rst_hold", {ifc.imem_req, ifc.ir_valid}, {1'b0, 1'b0});
        rst_f   = 1'b0;
        man_ack = 1'b0;
        step(1);
        check("rerun_no_req", ifc.imem_req, 1'b0);
        step(1);
        check("rerun_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 16'h0000});

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
